// File: rtl/serial_core_param.sv
// serial_core_param: accumulator core with a bit-serial ALU and a small register file.
// Optional feature macro: SERIAL_CORE_SHIFT_EN (opcode 7 = SHL, opcode F = SHR).
// Without it, opcodes 7 and F retire as NOPs.
module serial_core_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [3:0]                opcode,
    input  logic [$clog2(NREGS)-1:0]  rs_addr,
    input  logic [DATA_W-1:0]         imm,
    output logic                      done,
    output logic [DATA_W-1:0]         acc,
    output logic                      carry_flag,
    output logic                      zero_flag,
    input  logic [$clog2(NREGS)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]         dbg_data
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Parallel opcodes decoded at accept
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
`ifdef SERIAL_CORE_SHIFT_EN
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'hF;
`endif

    // Serial ALU function: low three opcode bits (shared by imm and reg forms)
    localparam logic [2:0] F_ADD = 3'd2;
    localparam logic [2:0] F_SUB = 3'd3;
    localparam logic [2:0] F_AND = 3'd4;
    localparam logic [2:0] F_OR  = 3'd5;
    localparam logic [2:0] F_XOR = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                accept;

    logic [2:0]          op_q;
    logic [DATA_W-1:0]   opnd_q;
    logic                sh_carry;
    logic [CNT_W-1:0]    cnt;

    logic                b_bit;
    logic                sum_bit;
    logic                carry_out;
    logic                res_bit;
    logic [DATA_W-1:0]   acc_shifted;

    logic [DATA_W-1:0]   regs [NREGS];

    // Opcodes 2-6 and A-E run through the serial ALU
    function automatic logic is_serial_op(input logic [3:0] op);
        return (op[2:0] >= F_ADD) && (op[2:0] <= F_XOR);
    endfunction

    assign accept   = instr_valid & instr_ready;
    assign dbg_data = regs[dbg_addr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = is_serial_op(opcode) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready <= 1'b1;
            done        <= 1'b0;
        end else begin
            instr_ready <= (next_state == ST_IDLE);
            done        <= (next_state == ST_DONE);
        end
    end

    // One-bit ALU slice: LSBs of acc and operand, result enters acc MSB
    always_comb begin
        b_bit     = opnd_q[0] ^ (op_q == F_SUB);
        sum_bit   = acc[0] ^ b_bit ^ sh_carry;
        carry_out = (acc[0] & b_bit) | (acc[0] & sh_carry) | (b_bit & sh_carry);
        res_bit   = sum_bit;
        case (op_q)
            F_AND:   res_bit = acc[0] & opnd_q[0];
            F_OR:    res_bit = acc[0] | opnd_q[0];
            F_XOR:   res_bit = acc[0] ^ opnd_q[0];
            default: res_bit = sum_bit;
        endcase
        acc_shifted = {res_bit, acc[DATA_W-1:1]};
    end

    // Accumulator, flags and serial working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            op_q       <= '0;
            opnd_q     <= '0;
            sh_carry   <= 1'b0;
            cnt        <= '0;
        end else if (accept) begin
            op_q     <= opcode[2:0];
            opnd_q   <= opcode[3] ? regs[rs_addr] : imm;
            sh_carry <= (opcode[2:0] == F_SUB);
            cnt      <= '0;
            case (opcode)
                OP_LDI: begin
                    acc       <= imm;
                    zero_flag <= (imm == '0);
                end
                OP_LD: begin
                    acc       <= regs[rs_addr];
                    zero_flag <= (regs[rs_addr] == '0);
                end
`ifdef SERIAL_CORE_SHIFT_EN
                OP_SHL: begin
                    acc        <= {acc[DATA_W-2:0], 1'b0};
                    carry_flag <= acc[DATA_W-1];
                    zero_flag  <= (acc[DATA_W-2:0] == '0);
                end
                OP_SHR: begin
                    acc        <= {1'b0, acc[DATA_W-1:1]};
                    carry_flag <= acc[0];
                    zero_flag  <= (acc[DATA_W-1:1] == '0);
                end
`endif
                default: ;
            endcase
        end else if (state == ST_SHIFT) begin
            acc      <= acc_shifted;
            opnd_q   <= {1'b0, opnd_q[DATA_W-1:1]};
            sh_carry <= carry_out;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
                zero_flag <= (acc_shifted == '0);
                if ((op_q == F_ADD) || (op_q == F_SUB)) begin
                    carry_flag <= carry_out;
                end
            end
        end
    end

    // Register file, written only by ST at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (accept && (opcode == OP_ST)) begin
            regs[rs_addr] <= acc;
        end
    end

endmodule

// File: tb/tb_serial_core_param.sv
// Randomized self-checking bench for serial_core_param (DATA_W=8, NREGS=4).
// Honors SERIAL_CORE_SHIFT_EN in its reference model when defined.
module tb_serial_core_param;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [1:0] rs_addr;
    logic [7:0] imm;
    logic       done;
    logic [7:0] acc;
    logic       carry_flag;
    logic       zero_flag;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference architectural state
    logic [7:0] m_acc;
    logic       m_c;
    logic       m_z;
    logic [7:0] m_regs [4];

    serial_core_param #(.DATA_W(8), .NREGS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rs_addr     (rs_addr),
        .imm         (imm),
        .done        (done),
        .acc         (acc),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_c   = 1'b0;
        m_z   = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    endtask

    // Architectural effect of one instruction; returns expected accept-to-done latency
    task automatic model_exec(input logic [3:0] op, input logic [1:0] rs,
                              input logic [7:0] im, output int lat);
        int unsigned a;
        int unsigned b;
        int unsigned s;
        a   = int'(m_acc);
        b   = op[3] ? int'(m_regs[rs]) : int'(im);
        lat = 1;
        case (op)
            4'h1: begin m_acc = im; m_z = (im == 8'h00); end
            4'h8: begin m_acc = m_regs[rs]; m_z = (m_acc == 8'h00); end
            4'h9: m_regs[rs] = m_acc;
            4'h2, 4'hA: begin
                s = a + b;
                m_acc = 8'(s); m_c = s[8]; m_z = (m_acc == 8'h00); lat = 9;
            end
            4'h3, 4'hB: begin
                s = a + (b ^ 32'hFF) + 1;
                m_acc = 8'(s); m_c = s[8]; m_z = (m_acc == 8'h00); lat = 9;
            end
            4'h4, 4'hC: begin m_acc = 8'(a & b); m_z = (m_acc == 8'h00); lat = 9; end
            4'h5, 4'hD: begin m_acc = 8'(a | b); m_z = (m_acc == 8'h00); lat = 9; end
            4'h6, 4'hE: begin m_acc = 8'(a ^ b); m_z = (m_acc == 8'h00); lat = 9; end
`ifdef SERIAL_CORE_SHIFT_EN
            4'h7: begin m_c = (a >= 128); m_acc = 8'(a * 2); m_z = (m_acc == 8'h00); end
            4'hF: begin m_c = (a % 2 == 1); m_acc = 8'(a / 2); m_z = (m_acc == 8'h00); end
`endif
            default: ;
        endcase
    endtask

    // Compare every register through the debug port (call while idle)
    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check(tag, int'(dbg_data), int'(m_regs[i]));
        end
    endtask

    // Issue one instruction, wait (bounded) for done, check result and handshake
    task automatic run_instr(input logic [3:0] op, input logic [1:0] rs,
                             input logic [7:0] im, input bit hold);
        int  lat_exp;
        int  k;
        bit  seen;
        model_exec(op, rs, im, lat_exp);
        @(negedge clk);
        check("ready_idle", int'(instr_ready), 1);
        instr_valid = 1'b1;
        opcode      = op;
        rs_addr     = rs;
        imm         = im;
        @(posedge clk);
        #1;
        if (hold) begin
            opcode = 4'h1;
            imm    = 8'h55;
        end else begin
            instr_valid = 1'b0;
        end
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
            else check("ready_busy", int'(instr_ready), 0);
        end
        instr_valid = 1'b0;
        check("latency", seen ? k : -1, lat_exp);
        check("acc", int'(acc), int'(m_acc));
        check("carry", int'(carry_flag), int'(m_c));
        check("zero", int'(zero_flag), int'(m_z));
        check("ready_in_done", int'(instr_ready), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("ready_back", int'(instr_ready), 1);
    endtask

    initial begin
        logic [3:0] r_op;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 4'h0;
        rs_addr     = 2'd0;
        imm         = 8'h00;
        dbg_addr    = 2'd0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_acc", int'(acc), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", int'(instr_ready), 1);
        check("rel_done", int'(done), 0);
        check("rel_acc", int'(acc), 0);
        check("rel_carry", int'(carry_flag), 0);
        check("rel_zero", int'(zero_flag), 0);
        check_regs("rel_regs");

        // Register add producing 0x80
        run_instr(4'h1, 2'd0, 8'h7F, 1'b0);
        run_instr(4'h9, 2'd2, 8'h00, 1'b0);
        run_instr(4'h1, 2'd0, 8'h01, 1'b0);
        run_instr(4'hA, 2'd2, 8'h00, 1'b0);
        check("add_acc", int'(acc), 8'h80);
        check("add_carry", int'(carry_flag), 0);
        check("add_zero", int'(zero_flag), 0);
        dbg_addr = 2'd2;
        #1;
        check("st_r2", int'(dbg_data), 8'h7F);

        // Wrap to zero, then a logic op keeps carry
        run_instr(4'h1, 2'd0, 8'hFF, 1'b0);
        run_instr(4'h2, 2'd0, 8'h01, 1'b0);
        check("wrap_acc", int'(acc), 0);
        check("wrap_carry", int'(carry_flag), 1);
        check("wrap_zero", int'(zero_flag), 1);
        run_instr(4'h4, 2'd0, 8'h0F, 1'b0);
        check("andi_acc", int'(acc), 0);
        check("andi_carry", int'(carry_flag), 1);

        // Subtract with and without borrow
        run_instr(4'h1, 2'd0, 8'h05, 1'b0);
        run_instr(4'h3, 2'd0, 8'h07, 1'b0);
        check("sub_borrow_acc", int'(acc), 8'hFE);
        check("sub_borrow_c", int'(carry_flag), 0);
        run_instr(4'h1, 2'd0, 8'h07, 1'b0);
        run_instr(4'h3, 2'd0, 8'h05, 1'b0);
        check("sub_ok_acc", int'(acc), 8'h02);
        check("sub_ok_c", int'(carry_flag), 1);

        // Opcode 7 after LDI 0x81
        run_instr(4'h1, 2'd0, 8'h81, 1'b0);
        run_instr(4'h7, 2'd0, 8'h00, 1'b0);
`ifdef SERIAL_CORE_SHIFT_EN
        check("op7_acc", int'(acc), 8'h02);
        check("op7_carry", int'(carry_flag), 1);
`else
        check("op7_acc", int'(acc), 8'h81);
`endif

        // instr_valid held during a serial op is ignored
        run_instr(4'h1, 2'd0, 8'h10, 1'b0);
        run_instr(4'h2, 2'd0, 8'h22, 1'b1);
        check("hold_acc", int'(acc), 8'h32);

        // Reset in the middle of SHIFT aborts the instruction
        @(negedge clk);
        instr_valid = 1'b1;
        opcode      = 4'h2;
        imm         = 8'h11;
        @(posedge clk);
        #1;
        opcode = 4'h1;
        imm    = 8'h55;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_acc", int'(acc), 0);
        check("abort_done", int'(done), 0);
        instr_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        check("abort_ready", int'(instr_ready), 1);
        check("abort_acc2", int'(acc), 0);
        check_regs("abort_regs");

        // Random instruction stream against the reference model
        for (int n = 0; n < 80; n++) begin
            r_op = 4'($urandom_range(0, 15));
            run_instr(r_op, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
            if (n % 8 == 7) check_regs("rand_regs");
        end
        check_regs("final_regs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_core_param.md
SERIAL_CORE_PARAM -- requirements
Module: serial_core_param

Interface
REQ-001 Parameter DATA_W, default 8: datapath/accumulator/register width in bits, SHALL be >=2.
REQ-002 Parameter NREGS, default 4: register-file depth, SHALL be a power of two >=2; ADDR_W = clog2(NREGS).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 instr_valid  input  1  instruction offered this cycle.
REQ-006 instr_ready  output  1  core idle and able to accept; high only in IDLE.
REQ-007 opcode  input  4  operation code, sampled on accept.
REQ-008 rs_addr  input  ADDR_W  register operand/destination index, sampled on accept.
REQ-009 imm  input  DATA_W  immediate operand, sampled on accept.
REQ-010 done  output  1  one-cycle pulse marking instruction retirement.
REQ-011 acc  output  DATA_W  accumulator contents.
REQ-012 carry_flag  output  1  carry/no-borrow flag.
REQ-013 zero_flag  output  1  accumulator-is-zero flag.
REQ-014 dbg_addr  input  ADDR_W  debug register select; dbg_data  output  DATA_W  combinational read of reg[dbg_addr].

Function
REQ-015 Accept = instr_valid && instr_ready; opcode, rs_addr, imm SHALL be latched only on accept; instr_valid outside IDLE SHALL be ignored.
REQ-016 Opcodes: 0 NOP; 1 LDI acc=imm; 2 ADDI; 3 SUBI; 4 ANDI; 5 ORI; 6 XORI; 8 LD acc=reg[rs]; 9 ST reg[rs]=acc; A ADD; B SUB; C AND; D OR; E XOR (A-E use reg[rs] as operand); 7, F reserved (see Configuration).
REQ-017 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on accept of opcode 2-6 or A-E; IDLE->DONE on accept of any other opcode; SHIFT->DONE after DATA_W shift cycles; DONE->IDLE unconditionally.
REQ-018 Parallel ops (LDI, LD, ST, NOP, reserved) SHALL complete on the accept edge; done high the following cycle (latency 1).
REQ-019 Serial ops SHALL process one bit per SHIFT cycle, LSB first, acc and operand shift registers shifting right, result bit entering acc MSB; done asserted in DONE, DATA_W+1 cycles after accept.
REQ-020 ADD: carry-in 0; SUB: operand bits inverted, carry-in 1 (two's complement); carry register updated every SHIFT cycle.
REQ-021 Arithmetic wraps modulo 2^DATA_W; carry_flag = final carry-out for ADD/ADDI/SUB/SUBI (SUB: 1 = no borrow); logic ops leave carry_flag unchanged.
REQ-022 zero_flag SHALL be updated to (acc==0) when any acc-writing op retires; ST and NOP leave both flags unchanged.
REQ-023 acc and flags SHALL present final values in the DONE cycle; intermediate acc values during SHIFT are not architectural.
REQ-024 ST to a register SHALL be visible on dbg_data the cycle after accept; regfile written only by ST.
REQ-025 done SHALL be high in exactly one cycle per accepted instruction; instr_ready low in SHIFT and DONE.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, acc=0, all registers=0, carry_flag=0, zero_flag=0, done=0, shift counter=0; instr_ready=1 after release.
REQ-027 Reset mid-SHIFT SHALL abort the instruction with no done pulse and no partial result retained.

Configuration
REQ-028 Macro SERIAL_CORE_SHIFT_EN defined: opcode 7 = SHL (acc<<1, LSB 0, carry_flag = old MSB), opcode F = SHR (acc>>1 logical, carry_flag = old LSB), both parallel ops (latency 1), zero_flag updated.
REQ-029 Macro undefined: opcodes 7 and F SHALL behave as NOP (latency 1, no state change except done pulse).

Verification (DATA_W=8, NREGS=4)
REQ-030 Reset release -> acc=0x00, instr_ready=1, done=0, carry_flag=0, zero_flag=0, dbg_data=0 for all dbg_addr.
REQ-031 LDI 0x7F; ST r2; LDI 0x01; ADD r2 -> acc=0x80, carry=0, zero=0, done 9 cycles after ADD accept; dbg_addr=2 -> 0x7F.
REQ-032 LDI 0xFF; ADDI 0x01 -> acc=0x00, carry=1, zero=1; then ANDI 0x0F -> acc=0x00, carry still 1.
REQ-033 LDI 0x05; SUBI 0x07 -> acc=0xFE, carry=0; LDI 0x07; SUBI 0x05 -> acc=0x02, carry=1.
REQ-034 instr_valid held high with LDI 0x55 during SHIFT -> ignored; rst_n pulsed low at SHIFT cycle 4 -> acc=0, no done, instr_ready=1 after release.
REQ-035 LDI 0x81; opcode 7 -> with SERIAL_CORE_SHIFT_EN acc=0x02, carry=1; without it acc=0x81, flags unchanged, done 1 cycle after accept.
